// File: rtl/mrd_sink_pack_p4_if.sv
// Upstream sample port and DFT sink port of the 4-lane frame packer.
interface mrd_sink_pack_p4_if #(
    parameter int DW = 18
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_sop;
    logic signed [DW-1:0] in_real;
    logic signed [DW-1:0] in_imag;
    logic [11:0]          cfg_dftpts;
    logic [5:0]           cfg_size;
    logic                 sink_valid;
    logic                 sink_ready;
    logic                 sink_sop;
    logic                 sink_eop;
    logic [0:3][DW-1:0]   sink_real;
    logic [0:3][DW-1:0]   sink_imag;
    logic [5:0]           size;
    logic                 frame_err;

    modport master (
        output in_valid, in_sop, in_real, in_imag, cfg_dftpts, cfg_size, sink_ready,
        input  in_ready, sink_valid, sink_sop, sink_eop, sink_real, sink_imag, size, frame_err
    );

    modport slave (
        input  in_valid, in_sop, in_real, in_imag, cfg_dftpts, cfg_size, sink_ready,
        output in_ready, sink_valid, sink_sop, sink_eop, sink_real, sink_imag, size, frame_err
    );
endinterface

// File: rtl/mrd_sink_pack_p4.sv
// Packs serial complex samples into 4-lane beats with sop/eop framing, buffered by a small beat FIFO.
module mrd_sink_pack_p4 #(
    parameter int DW    = 18,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mrd_sink_pack_p4_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = 8*DW + 2;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, PACK, DRAIN} state_t;
    state_t state, state_next;

    logic [EW-1:0]      mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        fifo_count;
    logic [1:0]         lane;
    logic [9:0]         beats_left;
    logic               first_beat;
    logic [0:2][DW-1:0] hold_real, hold_imag;
    logic [5:0]         size_q;
    logic               err_q;

    logic          ready, accept, push, pop, len_ok, err_event, sink_valid;
    logic [EW-1:0] wr_entry, head;

    assign len_ok = (bus.cfg_dftpts[1:0] == 2'b00) && (bus.cfg_dftpts >= 12'd12) &&
                    (bus.cfg_dftpts <= 12'd1200);
    assign ready      = (state != DRAIN) && (fifo_count < FULL);
    assign accept     = bus.in_valid && ready;
    assign sink_valid = (fifo_count != '0);
    assign pop        = sink_valid && bus.sink_ready;
    assign head       = mem[rd_ptr];
    assign wr_entry   = {hold_real, bus.in_real, hold_imag, bus.in_imag, first_beat, beats_left == 10'd1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && bus.in_sop && len_ok) state_next = PACK;
            PACK:    if (push && beats_left == 10'd1)   state_next = DRAIN;
            DRAIN:   if (pop && head[0])                 state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        push      = 1'b0;
        err_event = 1'b0;
        case (state)
            IDLE: err_event = accept && bus.in_sop && !len_ok;
            PACK: begin
                push      = accept && (lane == 2'd3);
                err_event = accept && bus.in_sop;
            end
            default: ;
        endcase
    end

    // Lanes 0..2 wait in holding registers; the lane-3 sample goes straight into the FIFO entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane       <= 2'd0;
            beats_left <= 10'd0;
            first_beat <= 1'b0;
            hold_real  <= '0;
            hold_imag  <= '0;
            size_q     <= 6'd0;
            err_q      <= 1'b0;
        end else begin
            err_q <= err_event;
            if (state == IDLE && accept && bus.in_sop && len_ok) begin
                hold_real[0] <= bus.in_real;
                hold_imag[0] <= bus.in_imag;
                lane         <= 2'd1;
                beats_left   <= bus.cfg_dftpts[11:2];
                first_beat   <= 1'b1;
                size_q       <= bus.cfg_size;
            end else if (state == PACK && accept) begin
                if (lane == 2'd3) begin
                    lane       <= 2'd0;
                    beats_left <= beats_left - 10'd1;
                    first_beat <= 1'b0;
                end else begin
                    hold_real[lane] <= bus.in_real;
                    hold_imag[lane] <= bus.in_imag;
                    lane            <= lane + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (!push && pop) fifo_count <= fifo_count - 1'b1;
        end
    end

    // Head fields are forced to zero when empty so stale entries never show on the sink bus.
    assign bus.in_ready   = rst_n && ready;
    assign bus.sink_valid = sink_valid;
    assign bus.sink_real  = sink_valid ? head[EW-1 -: 4*DW]      : '0;
    assign bus.sink_imag  = sink_valid ? head[EW-4*DW-1 -: 4*DW] : '0;
    assign bus.sink_sop   = sink_valid && head[1];
    assign bus.sink_eop   = sink_valid && head[0];
    assign bus.size       = size_q;
    assign bus.frame_err  = err_q;
endmodule

// File: tb/tb_mrd_sink_pack_p4.sv
// Directed bench for the 4-lane sink packer: frames push expected beats, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_mrd_sink_pack_p4;
    localparam int DW    = 18;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [0:3][DW-1:0] re;
        logic [0:3][DW-1:0] im;
        logic               sop;
        logic               eop;
        logic [5:0]         size;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mrd_sink_pack_p4_if #(.DW(DW)) bus ();
    mrd_sink_pack_p4 #(.DW(DW), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    beat_t exp_q[$];
    beat_t mon_e;
    int    checks     = 0;
    int    errors     = 0;
    int    cyc        = 0;
    int    err_pulses = 0;
    int    eop_edge   = -1;
    int    beats_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_lanes(input string name, input logic [8*DW-1:0] act, input logic [8*DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Monitor: every valid cycle is compared against the queue head, so stalled beats must hold steady.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.frame_err) err_pulses++;
            if (bus.sink_valid) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected beat", int'(bus.sink_valid), 0);
                end else begin
                    mon_e = exp_q[0];
                    check_lanes("beat data", {bus.sink_real, bus.sink_imag}, {mon_e.re, mon_e.im});
                    check_output("beat sop/eop", int'({bus.sink_sop, bus.sink_eop}), int'({mon_e.sop, mon_e.eop}));
                    check_output("size", int'(bus.size), int'(mon_e.size));
                    if (bus.sink_ready) begin
                        void'(exp_q.pop_front());
                        beats_seen++;
                        if (mon_e.eop) begin
                            eop_edge = cyc + 1;
                            check_output("in_ready in DRAIN", int'(bus.in_ready), 0);
                        end
                    end
                end
            end
        end
    end

    task automatic apply_stimulus(input logic sop, input int val, input int pts, input logic [5:0] sz,
                                  output int acc_edge);
        bus.in_valid   = 1'b1;
        bus.in_sop     = sop;
        bus.in_real    = DW'(val);
        bus.in_imag    = DW'(-val);
        bus.cfg_dftpts = 12'(pts);
        bus.cfg_size   = sz;
        acc_edge       = -1;
        for (int w = 0; w < 500; w++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc_edge = cyc + 1;
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        fail_timeout("in_ready wait");
    endtask

    task automatic push_expected(input int pts, input logic [5:0] sz, input int base);
        beat_t b;
        int    nb = pts / 4;
        for (int i = 0; i < nb; i++) begin
            for (int k = 0; k < 4; k++) begin
                b.re[k] = DW'(base + 4*i + k + 1);
                b.im[k] = DW'(-(base + 4*i + k + 1));
            end
            b.sop  = (i == 0);
            b.eop  = (i == nb - 1);
            b.size = sz;
            exp_q.push_back(b);
        end
    endtask

    task automatic send_samples(input int pts, input logic [5:0] sz, input int base, input int first,
                                input int last, input int extra_sop, output int first_edge);
        int e;
        first_edge = -1;
        for (int n = first; n < last; n++) begin
            apply_stimulus((n == 0) || (n == extra_sop), base + n + 1, pts, sz, e);
            if (n == first) first_edge = e;
        end
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int w;
        for (w = 0; w < bound; w++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        if (w == bound) fail_timeout("drain");
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $finish;
    end

    initial begin
        int e, b0, p0, eop1, sop2;
        bus.in_valid   = 1'b0;
        bus.in_sop     = 1'b0;
        bus.in_real    = '0;
        bus.in_imag    = '0;
        bus.cfg_dftpts = 12'd0;
        bus.cfg_size   = 6'd0;
        bus.sink_ready = 1'b1;

        // Reset values while held and right after release.
        #12;
        check_output("rst in_ready", int'(bus.in_ready), 0);
        check_output("rst sink_valid", int'(bus.sink_valid), 0);
        check_output("rst sop/eop/err", int'({bus.sink_sop, bus.sink_eop, bus.frame_err}), 0);
        check_output("rst size", int'(bus.size), 0);
        check_lanes("rst lanes", {bus.sink_real, bus.sink_imag}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("in_ready after release", int'(bus.in_ready), 1);

        $display("[TB] nominal 12-point frame");
        b0 = beats_seen;
        push_expected(12, 6'd5, 0);
        send_samples(12, 6'd5, 0, 0, 4, -1, e);
        check_output("latency sink_valid", int'(bus.sink_valid), 1);
        send_samples(12, 6'd5, 0, 4, 12, -1, e);
        idle_inputs();
        wait_drain(100);
        check_output("nominal beat count", beats_seen - b0, 3);

        $display("[TB] backpressure 48-point frame");
        b0 = beats_seen;
        bus.sink_ready = 1'b0;
        push_expected(48, 6'd7, 200);
        fork
            begin
                repeat (20) @(posedge clk);
                #1;
                bus.sink_ready = 1'b1;
            end
            begin
                send_samples(48, 6'd7, 200, 0, 15, -1, e);
                check_output("in_ready before full", int'(bus.in_ready), 1);
                send_samples(48, 6'd7, 200, 15, 16, -1, e);
                check_output("in_ready when full", int'(bus.in_ready), 0);
                send_samples(48, 6'd7, 200, 16, 48, -1, e);
            end
        join
        idle_inputs();
        wait_drain(200);
        check_output("backpressure beat count", beats_seen - b0, 12);

        $display("[TB] illegal lengths");
        b0 = beats_seen;
        p0 = err_pulses;
        apply_stimulus(1'b1, 999, 10, 6'd3, e);
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_output("frame_err len 10", err_pulses - p0, 1);
        check_output("idle after len 10", int'(bus.in_ready), 1);
        apply_stimulus(1'b1, 998, 1204, 6'd3, e);
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_output("frame_err len 1204", err_pulses - p0, 2);
        push_expected(24, 6'd9, 300);
        send_samples(24, 6'd9, 300, 0, 24, -1, e);
        idle_inputs();
        wait_drain(100);
        check_output("legal 24 beat count", beats_seen - b0, 6);

        $display("[TB] stray samples and mid-frame sop");
        b0 = beats_seen;
        p0 = err_pulses;
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 900 + i, 24, 6'd4, e);
        push_expected(24, 6'd4, 400);
        send_samples(24, 6'd4, 400, 0, 24, 8, e);
        idle_inputs();
        wait_drain(100);
        check_output("stray sop frame_err", err_pulses - p0, 1);
        check_output("stray beat count", beats_seen - b0, 6);

        $display("[TB] reset mid-frame");
        b0 = beats_seen;
        push_expected(1200, 6'd11, 1000);
        send_samples(1200, 6'd11, 1000, 0, 8, -1, e);
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_output("beats before reset", beats_seen - b0, 2);
        rst_n = 1'b0;
        #1;
        check_output("mid rst in_ready", int'(bus.in_ready), 0);
        check_output("mid rst size", int'(bus.size), 0);
        check_output("mid rst valid/sop/eop", int'({bus.sink_valid, bus.sink_sop, bus.sink_eop}), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_output("in_ready after mid reset", int'(bus.in_ready), 1);
        b0 = beats_seen;
        push_expected(12, 6'd12, 500);
        send_samples(12, 6'd12, 500, 0, 12, -1, e);
        idle_inputs();
        wait_drain(100);
        check_output("post-reset beat count", beats_seen - b0, 3);

        $display("[TB] back-to-back frames");
        b0 = beats_seen;
        push_expected(12, 6'd13, 600);
        push_expected(1200, 6'd14, 700);
        send_samples(12, 6'd13, 600, 0, 12, -1, e);
        send_samples(1200, 6'd14, 700, 0, 1, -1, sop2);
        eop1 = eop_edge;
        send_samples(1200, 6'd14, 700, 1, 1200, -1, e);
        idle_inputs();
        wait_drain(2000);
        check_output("second sop edge", sop2, eop1 + 1);
        check_output("back-to-back beat count", beats_seen - b0, 303);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mrd_sink_pack_p4.md
# mrd_sink_pack_p4

Frame packer and transmitter for the 4-lane sink side of the mixed-radix DFT core. It accepts one complex sample per cycle from an upstream serial source and groups four consecutive samples into one 4-lane beat. Beats leave over the DFT sink interface with sop/eop framing and the DFT size code held stable for the whole frame. Backpressure from the DFT's `sink_ready` is absorbed by a small beat FIFO and propagated upstream as `in_ready`.

## Interface
- `DW`, default 18: sample component width, matching the DFT lane width.
- `DEPTH`, default 4: beat FIFO depth, power of two, at least 2.
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: upstream sample valid.
- `in_ready` out 1: packer can take a sample. A sample transfers on `in_valid && in_ready`.
- `in_sop` in 1: the sample is the first of a frame.
- `in_real`, `in_imag` in DW each: signed sample.
- `cfg_dftpts` in 12: frame length in points. Sampled with the sop sample.
- `cfg_size` in 6: DFT size code. Sampled with the sop sample.
- `sink_valid` out 1: beat valid toward the DFT.
- `sink_ready` in 1: DFT accepts the beat. A beat transfers on `sink_valid && sink_ready`.
- `sink_sop`, `sink_eop` out 1 each: first and last beat of the frame.
- `sink_real[0:3]`, `sink_imag[0:3]` out DW each: lane k carries sample 4·b+k of beat b.
- `size` out 6: latched `cfg_size`, stable from the sop beat through the accepted eop beat.
- `frame_err` out 1: one-cycle pulse on a rejected sop or a stray sop.

## Operation
- FSM states: IDLE, PACK, DRAIN.
- **IDLE**
  - `in_ready` = 1.
  - Samples without `in_sop` are dropped silently.
  - A sop sample latches `cfg_dftpts` and `cfg_size`, then checks the frame length.
  - Length is legal if `cfg_dftpts` is a multiple of 4 and lies in 12..1200.
  - Illegal length: pulse `frame_err`, drop the sample, stay in IDLE.
  - Legal length: the sample fills lane 0, load `beats_left = dftpts/4`, go to PACK.
- **PACK**
  - A 2-bit lane counter fills lanes 0..2 into holding registers.
  - The sample that completes lane 3 is combined with the held lanes and written into the FIFO on that same edge.
  - Each FIFO entry is {4×real, 4×imag, sop, eop}.
  - sop is set on the first beat of the frame; eop is set when `beats_left` == 1.
  - `beats_left` decrements on each FIFO write.
  - The eop write moves the FSM to DRAIN.
  - `in_sop` seen during PACK: pulse `frame_err`, treat the sample as an ordinary data sample, keep counting.
- **DRAIN**
  - `in_ready` = 0.
  - Return to IDLE on the cycle after the eop beat is accepted by the DFT.
- **`in_ready` rule**
  - `in_ready` = (state ≠ DRAIN) && (`fifo_count` < DEPTH), where `fifo_count` is registered.
  - This guarantees room for the lane-3 write.
- **FIFO output**
  - `sink_valid` = FIFO not empty.
  - Sink data, sop and eop come from the registered FIFO head.
  - These outputs are held unchanged while `sink_valid && !sink_ready`.
- **Simultaneous events**
  - FIFO push and pop in the same cycle leave the count unchanged.
  - Pop on full plus push in the same cycle is legal. `in_ready` still reads 0 that cycle because it uses the registered count.
- **Arithmetic**
  - Samples pass through bit-exact; no scaling, no reordering.
  - Packing follows arrival order.

## Timing
- Reset values:
  - `in_ready` = 0 while `rst_n` is low, 1 on the first cycle after release.
  - `sink_valid`, `sink_sop`, `sink_eop`, `frame_err` = 0.
  - Lanes = 0, `size` = 0, FIFO empty, state IDLE.
- Latency: lane-3 sample accepted at edge t gives `sink_valid` = 1 in cycle t+1 when the FIFO was empty.
- Throughput: with `sink_ready` held at 1, one beat per 4 input samples; there are no bubbles inside a frame.
- Frame gap: at least 1 cycle of DRAIN after the eop beat is accepted before the next sop is taken.
- Reset asserted mid-frame: immediate flush. The partial frame is discarded and nothing is emitted after release until a new sop.
- `size` updates only on a sop accepted in IDLE.

## Test plan
- **Nominal frame:** `cfg_dftpts` = 12, `cfg_size` = 5, samples 1..12, `sink_ready` = 1 → 3 beats {1,2,3,4}, {5,6,7,8}, {9,10,11,12}; sop on beat 0, eop on beat 2; `size` = 5 throughout; first `sink_valid` one cycle after sample 4.
- **Backpressure:** `cfg_dftpts` = 48, `sink_ready` low for 20 cycles from the start → `in_ready` falls after DEPTH=4 beats (16 samples); no beat lost or duplicated; sink outputs stable while stalled; all 12 beats arrive in order once ready rises.
- **Illegal length:** sop with `cfg_dftpts` = 10, then with 1204 → `frame_err` pulses once each; no `sink_valid`; FSM stays IDLE; a following legal sop with 24 produces 6 beats.
- **Stray and pre-sop samples:** 3 samples without sop in IDLE, then a frame of 24 with an extra `in_sop` on sample 9 → the first 3 samples are dropped; one `frame_err` pulse; 6 beats emitted with sample 9 in beat 2 lane 0.
- **Reset mid-frame:** assert `rst_n` low after beat 1 of a 1200-point frame → all outputs return to reset values asynchronously; after release, a fresh 12-point frame emits exactly 3 beats with a correct sop.
- **Back-to-back frames:** two frames of 12 and 1200 points with `in_valid` held high → no `in_ready` during DRAIN; the second sop is accepted one cycle after the first eop handshake; 300 beats with the correct eop.
